// File: rtl/trigger_pkg.sv
// Shared types and constants for the acquisition trigger stage.
package trigger_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        ARMED,
        HOLDOFF
    } trig_state_t;

    typedef enum logic {
        RISING  = 1'b0,
        FALLING = 1'b1
    } slope_t;

    localparam int unsigned TRIG_COUNT_WIDTH = 16;

endpackage

// File: rtl/trigger_threshold.sv
// Registered, saturating prime/trigger threshold computation.
// Thresholds and slope are captured only on the load strobe (arm acceptance),
// so later changes to level/hyst/slope do not disturb an armed capture.
module trigger_threshold
    import trigger_pkg::*;
#(
    parameter int unsigned SAMPLE_DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_i,
    input  logic                         slope_i,
    input  logic [SAMPLE_DATA_WIDTH-1:0] level_i,
    input  logic [SAMPLE_DATA_WIDTH-1:0] hyst_i,
    output logic [SAMPLE_DATA_WIDTH-1:0] prime_th_o,
    output logic [SAMPLE_DATA_WIDTH-1:0] trig_th_o,
    output slope_t                       slope_o
);

    logic [SAMPLE_DATA_WIDTH:0]   sum_w;
    logic [SAMPLE_DATA_WIDTH:0]   diff_w;
    logic [SAMPLE_DATA_WIDTH-1:0] prime_th_d;
    logic [SAMPLE_DATA_WIDTH-1:0] prime_th_q;
    logic [SAMPLE_DATA_WIDTH-1:0] trig_th_q;
    slope_t                       slope_q;

    // Width+1 arithmetic: the extra bit flags overflow (falling) or borrow (rising)
    always_comb begin
        sum_w  = {1'b0, level_i} + {1'b0, hyst_i};
        diff_w = {1'b0, level_i} - {1'b0, hyst_i};
        prime_th_d = '0;
        if (slope_t'(slope_i) == FALLING) begin
            prime_th_d = sum_w[SAMPLE_DATA_WIDTH] ? '1 : sum_w[SAMPLE_DATA_WIDTH-1:0];
        end else begin
            prime_th_d = diff_w[SAMPLE_DATA_WIDTH] ? '0 : diff_w[SAMPLE_DATA_WIDTH-1:0];
        end
    end

    // Capture thresholds and slope on arm acceptance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prime_th_q <= '0;
            trig_th_q  <= '0;
            slope_q    <= RISING;
        end else if (load_i) begin
            prime_th_q <= prime_th_d;
            trig_th_q  <= level_i;
            slope_q    <= slope_t'(slope_i);
        end
    end

    assign prime_th_o = prime_th_q;
    assign trig_th_o  = trig_th_q;
    assign slope_o    = slope_q;

endmodule

// File: rtl/trigger_unit.sv
// Level-crossing trigger with hysteresis and post-trigger holdoff.
// Forwards the sample stream with one cycle of latency and pulses `trigger`
// alongside the forwarded crossing sample.
// Build option: define TRIGGER_AUTO_REARM_EN to return to PRIME after holdoff
// (continuous re-arming); otherwise the unit returns to IDLE (single shot).
module trigger_unit
    import trigger_pkg::*;
#(
    parameter int unsigned SAMPLE_DATA_WIDTH = 8,
    parameter int unsigned HOLDOFF_SAMPLES   = 1000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         slope,
    input  logic [SAMPLE_DATA_WIDTH-1:0] level,
    input  logic [SAMPLE_DATA_WIDTH-1:0] hyst,
    input  logic                         axiiv,
    input  logic [SAMPLE_DATA_WIDTH-1:0] axiid,
    output logic                         axiov,
    output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
    output logic                         trigger,
    output logic                         armed,
    output logic [TRIG_COUNT_WIDTH-1:0]  trig_count
);

    // A zero-length holdoff still needs a legal (unused) counter width
    localparam int unsigned HOLD_W = (HOLDOFF_SAMPLES > 0) ? $clog2(HOLDOFF_SAMPLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (HOLDOFF_SAMPLES > 0) ? HOLD_W'(HOLDOFF_SAMPLES - 1) : '0;

`ifdef TRIGGER_AUTO_REARM_EN
    localparam trig_state_t POST_HOLD = PRIME;
`else
    localparam trig_state_t POST_HOLD = IDLE;
`endif
    localparam logic POST_ARMED = (POST_HOLD == PRIME);

    trig_state_t                   state_q;
    logic [HOLD_W-1:0]             hold_cnt_q;
    logic                          trigger_q;
    logic                          armed_q;
    logic [TRIG_COUNT_WIDTH-1:0]   count_q;
    logic [TRIG_COUNT_WIDTH-1:0]   count_d;
    logic                          axiov_q;
    logic [SAMPLE_DATA_WIDTH-1:0]  axiod_q;

    logic                          arm_accept;
    logic [SAMPLE_DATA_WIDTH-1:0]  prime_th;
    logic [SAMPLE_DATA_WIDTH-1:0]  trig_th;
    slope_t                        slope_l;
    logic                          prime_hit;
    logic                          trig_hit;

    assign arm_accept = (state_q == IDLE) && arm;

    trigger_threshold #(
        .SAMPLE_DATA_WIDTH (SAMPLE_DATA_WIDTH)
    ) u_threshold (
        .clk        (clk),
        .rst        (rst),
        .load_i     (arm_accept),
        .slope_i    (slope),
        .level_i    (level),
        .hyst_i     (hyst),
        .prime_th_o (prime_th),
        .trig_th_o  (trig_th),
        .slope_o    (slope_l)
    );

    // Threshold comparisons for the incoming sample and saturating count increment
    always_comb begin
        if (slope_l == FALLING) begin
            prime_hit = (axiid >= prime_th);
            trig_hit  = (axiid <= trig_th);
        end else begin
            prime_hit = (axiid <= prime_th);
            trig_hit  = (axiid >= trig_th);
        end
        count_d = (count_q == '1) ? count_q : count_q + 1'b1;
    end

    // Sample forwarding: one cycle of latency, independent of trigger state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            axiov_q <= 1'b0;
            axiod_q <= '0;
        end else begin
            axiov_q <= axiiv;
            axiod_q <= axiid;
        end
    end

    // Trigger FSM with registered trigger/armed outputs, holdoff and trigger counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            trigger_q  <= 1'b0;
            armed_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            trigger_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_q <= PRIME;
                        armed_q <= 1'b1;
                    end
                end
                PRIME: begin
                    // A sample meeting both thresholds only primes here
                    if (axiiv && prime_hit) begin
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    if (axiiv && trig_hit) begin
                        trigger_q <= 1'b1;
                        count_q   <= count_d;
                        if (HOLDOFF_SAMPLES == 0) begin
                            state_q <= POST_HOLD;
                            armed_q <= POST_ARMED;
                        end else begin
                            state_q    <= HOLDOFF;
                            armed_q    <= 1'b0;
                            hold_cnt_q <= '0;
                        end
                    end
                end
                HOLDOFF: begin
                    if (axiiv) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            state_q <= POST_HOLD;
                            armed_q <= POST_ARMED;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    armed_q <= 1'b0;
                end
            endcase
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign trigger    = trigger_q;
    assign armed      = armed_q;
    assign trig_count = count_q;

endmodule

// File: tb/tb_trigger_unit.sv
// Self-checking bench for trigger_unit: directed tables, hand-written corner
// sequences and randomized stimulus against a behavioural reference model.
module tb_trigger_unit;

    localparam int HOLD = 4;
`ifdef TRIGGER_AUTO_REARM_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        slope;
    logic [7:0]  level;
    logic [7:0]  hyst;
    logic        axiiv;
    logic [7:0]  axiid;
    logic        axiov;
    logic [7:0]  axiod;
    logic        trigger;
    logic        armed;
    logic [15:0] trig_count;

    trigger_unit #(
        .SAMPLE_DATA_WIDTH (8),
        .HOLDOFF_SAMPLES   (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .slope      (slope),
        .level      (level),
        .hyst       (hyst),
        .axiiv      (axiiv),
        .axiid      (axiid),
        .axiov      (axiov),
        .axiod      (axiod),
        .trigger    (trigger),
        .armed      (armed),
        .trig_count (trig_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase 0 = waiting for arm, 1 = waiting for the sample
    // beyond the hysteresis band, 2 = waiting for the level crossing,
    // 3 = ignoring m_left more valid samples.
    int m_phase, m_left, m_pth, m_tth, m_count;
    bit m_fall, m_v, m_trig, m_armed;
    int m_d;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_pth = 0; m_tth = 0; m_count = 0;
        m_fall = 0; m_v = 0; m_trig = 0; m_armed = 0; m_d = 0;
    endtask

    task automatic model_edge(input bit a, input bit s, input int lv, input int hy,
                              input bit v, input int d);
        m_v = v; m_d = d; m_trig = 0;
        case (m_phase)
            0: if (a) begin
                m_fall = s;
                m_tth  = lv;
                if (s) m_pth = (lv + hy > 255) ? 255 : lv + hy;
                else   m_pth = (lv - hy < 0) ? 0 : lv - hy;
                m_phase = 1;
            end
            1: if (v && (m_fall ? (d >= m_pth) : (d <= m_pth))) m_phase = 2;
            2: if (v && (m_fall ? (d <= m_tth) : (d >= m_tth))) begin
                m_trig = 1;
                if (m_count < 65535) m_count++;
                if (HOLD > 0) begin m_phase = 3; m_left = HOLD; end
                else m_phase = AUTO ? 1 : 0;
            end
            3: if (v) begin
                m_left--;
                if (m_left == 0) m_phase = AUTO ? 1 : 0;
            end
            default: m_phase = 0;
        endcase
        m_armed = (m_phase == 1) || (m_phase == 2);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string name);
        total++;
        if (axiov !== m_v || int'(axiod) != m_d || trigger !== m_trig ||
            armed !== m_armed || int'(trig_count) != m_count) begin
            bad++;
            $display("FAIL %s: got v=%0b d=%0d trig=%0b armed=%0b cnt=%0d expected v=%0b d=%0d trig=%0b armed=%0b cnt=%0d at %0t",
                     name, axiov, axiod, trigger, armed, trig_count,
                     m_v, m_d, m_trig, m_armed, m_count, $time);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare 1 time unit later
    task automatic step(input bit a, input bit s, input int lv, input int hy,
                        input bit v, input int d, input string name);
        arm = a; slope = s; level = lv[7:0]; hyst = hy[7:0];
        axiiv = v; axiid = d[7:0];
        @(posedge clk);
        model_edge(a, s, lv, hy, v, d);
        #1;
        check_model(name);
    endtask

    task automatic do_reset();
        arm = 0; slope = 0; level = 0; hyst = 0; axiiv = 0; axiid = 0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        chk("reset_axiov", int'(axiov), 0);
        chk("reset_trigger", int'(trigger), 0);
        chk("reset_armed", int'(armed), 0);
        chk("reset_count", int'(trig_count), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit a; bit s; int lv; int hy; bit v; int d;
        bit e_trig; bit e_armed;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int ntrig, trig_d, trig_armed, trig_cnt, sq[4];
        rst = 1'b0;
        model_reset();

        // Rising ramp: prime at 90, trigger on 100
        do_reset();
        step(1, 0, 100, 10, 1, 0, "ramp_arm");
        ntrig = 0; trig_d = -1; trig_armed = -1; trig_cnt = -1;
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 0, 0, 1, i, "ramp");
            if (trigger) begin
                ntrig++; trig_d = int'(axiod); trig_armed = int'(armed); trig_cnt = int'(trig_count);
            end
        end
        chk("ramp_ntrig", ntrig, 1);
        chk("ramp_trig_sample", trig_d, 100);
        chk("ramp_armed_at_trig", trig_armed, 0);
        chk("ramp_count_at_trig", trig_cnt, 1);

        // Falling with saturated prime threshold (250+10 -> 255)
        do_reset();
        tbl.push_back('{1, 1, 250, 10, 1, 0,   0, 1});
        tbl.push_back('{0, 1, 0,   0,  1, 255, 0, 1});
        tbl.push_back('{0, 1, 0,   0,  1, 255, 0, 1});
        tbl.push_back('{0, 1, 0,   0,  1, 240, 1, 0});
        tbl.push_back('{0, 1, 0,   0,  1, 0,   0, 0});
        tbl.push_back('{0, 1, 0,   0,  1, 0,   0, 0});
        tbl.push_back('{0, 1, 0,   0,  1, 0,   0, 0});
        tbl.push_back('{0, 1, 0,   0,  1, 0,   0, AUTO});
        tbl.push_back('{1, 1, 250, 10, 1, 0,   0, 1});
        tbl.push_back('{0, 1, 250, 10, 0, 255, 0, 1});
        tbl.push_back('{0, 1, 250, 10, 1, 254, 0, 1});
        tbl.push_back('{0, 1, 250, 10, 1, 240, 0, 1});
        foreach (tbl[i]) begin
            step(tbl[i].a, tbl[i].s, tbl[i].lv, tbl[i].hy, tbl[i].v, tbl[i].d, "fall_tbl");
            chk("fall_tbl_trig", int'(trigger), int'(tbl[i].e_trig));
            chk("fall_tbl_armed", int'(armed), int'(tbl[i].e_armed));
        end
        chk("fall_count", int'(trig_count), 1);

        // Square wave 0,0,200,200 after one arm
        do_reset();
        sq = '{0, 0, 200, 200};
        step(1, 0, 100, 10, 1, 0, "sq_arm");
        ntrig = 0;
        for (int i = 0; i < 24; i++) begin
            step(0, 0, 0, 0, 1, sq[i % 4], "sq");
            if (trigger) ntrig++;
        end
        chk("sq_ntrig", ntrig, AUTO ? 3 : 1);
        chk("sq_count", int'(trig_count), AUTO ? 3 : 1);
        step(1, 0, 100, 10, 1, 0, "sq_rearm");
        ntrig = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 1, sq[i % 4], "sq2");
            if (trigger) ntrig++;
        end
        chk("sq_rearm_ntrig", ntrig, 1);

        // Invalid cycles stretch the holdoff window
        do_reset();
        step(1, 0, 100, 10, 1, 0, "gap_arm");
        step(0, 0, 0, 0, 1, 0, "gap_prime");
        step(0, 0, 0, 0, 1, 200, "gap_trig");
        chk("gap_trig", int'(trigger), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "gap_hold");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, "gap_idle");
        chk("gap_armed_held", int'(armed), 0);
        step(0, 0, 0, 0, 1, 0, "gap_last");
        chk("gap_armed_after", int'(armed), int'(AUTO));

        // Arm while ARMED with a different level is ignored
        do_reset();
        step(1, 0, 100, 10, 1, 0, "rearm_arm");
        step(0, 0, 0, 0, 1, 50, "rearm_prime");
        step(1, 0, 50, 0, 1, 0, "rearm_ignored");
        step(0, 0, 50, 0, 1, 60, "rearm_60");
        chk("rearm_no_trig_60", int'(trigger), 0);
        step(0, 0, 50, 0, 1, 150, "rearm_150");
        chk("rearm_trig_150", int'(trigger), 1);

        // Asynchronous reset during holdoff, then crossings without arm
        do_reset();
        step(1, 0, 100, 10, 1, 0, "rh_arm");
        step(0, 0, 0, 0, 1, 0, "rh_prime");
        step(0, 0, 0, 0, 1, 200, "rh_trig");
        step(0, 0, 0, 0, 1, 200, "rh_hold");
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rh_axiov", int'(axiov), 0);
        chk("rh_axiod", int'(axiod), 0);
        chk("rh_trigger", int'(trigger), 0);
        chk("rh_armed", int'(armed), 0);
        chk("rh_count", int'(trig_count), 0);
        @(negedge clk);
        rst = 1'b1;
        ntrig = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 100, 10, 1, sq[i % 4], "rh_noarm");
            if (trigger) ntrig++;
        end
        chk("rh_noarm_ntrig", ntrig, 0);

        // Randomized stimulus against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit ra, rs, rv;
            int rl, rh, rd;
            ra = ($urandom_range(0, 15) == 0);
            rs = $urandom_range(0, 1) == 1;
            rl = $urandom_range(0, 255);
            rh = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 60);
            rv = ($urandom_range(0, 3) != 0);
            rd = $urandom_range(0, 255);
            step(ra, rs, rl, rh, rv, rd, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
